prog_loader: RTL
================

PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter: ADDR_W, 8, program-memory address width; depth 2^ADDR_W words.
REQ-002 Parameter: WORD_W, 40, instruction width; fixed at 5 bytes per word.
REQ-003 Port: i_clk  input  1  sole clock; all logic on rising edge.
REQ-004 Port: i_rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port: i_start  input  1  single-cycle request to begin a program load.
REQ-006 Port: i_byte  input  8  incoming load-stream byte.
REQ-007 Port: i_byte_valid  input  1  i_byte is valid this cycle.
REQ-008 Port: o_byte_ready  output  1  loader can accept a byte this cycle.
REQ-009 Port: o_mem_we  output  1  one-cycle program-memory write strobe.
REQ-010 Port: o_mem_addr  output  ADDR_W  write address.
REQ-011 Port: o_mem_wdata  output  WORD_W  write data.
REQ-012 Port: o_cpu_run  output  1  high when the CPU may execute; CPU held at PC 0 while low.
REQ-013 Port: o_busy  output  1  high while a load is in progress.
REQ-014 Port: o_error  output  1  checksum failure, sticky until next i_start or reset.

Function
REQ-015 States SHALL be IDLE, HDR, DATA, CSUM, DONE, ERR.
REQ-016 A byte SHALL be accepted only on a cycle with i_byte_valid and o_byte_ready both high.
REQ-017 o_byte_ready SHALL be high exactly in HDR, DATA, CSUM; o_busy SHALL be high in the same states.
REQ-018 i_start in IDLE, DONE or ERR SHALL move to HDR next cycle: clear o_cpu_run, o_error, word counter, byte counter, checksum.
REQ-019 i_start in HDR, DATA or CSUM SHALL be ignored.
REQ-020 HDR: accepted byte N gives word count; N=0 means 256 (2^ADDR_W) words; then DATA.
REQ-021 DATA: bytes arrive MSB first; byte k (0..4) of a word lands in bits [39-8k:32-8k].
REQ-022 Every accepted DATA byte SHALL be XORed into an 8-bit checksum register; header byte excluded.
REQ-023 On the cycle after the 5th byte of a word is accepted: o_mem_we high for exactly one cycle, o_mem_addr = word index (0-based), o_mem_wdata = assembled word.
REQ-024 A byte accepted in the same cycle o_mem_we is high SHALL start the next word without loss (no bubble required on the stream).
REQ-025 Word index SHALL increment after each write; after word N-1, next state is CSUM; index is ADDR_W+1 bits wide internally so count 256 does not wrap early.
REQ-026 CSUM: accepted byte equal to checksum -> DONE; otherwise -> ERR.
REQ-027 DONE: o_cpu_run=1, o_error=0; ERR: o_cpu_run=0, o_error=1.
REQ-028 o_mem_we SHALL be low in all states except the REQ-023 strobe; o_mem_addr/o_mem_wdata hold last written values otherwise.
REQ-029 i_byte_valid high while o_byte_ready low SHALL be ignored, no state change.

Reset
REQ-030 i_rst_n low SHALL immediately force IDLE with o_byte_ready, o_mem_we, o_cpu_run, o_busy, o_error = 0 and o_mem_addr, o_mem_wdata, counters, checksum = 0.
REQ-031 Reset mid-load SHALL abandon the load; partial word SHALL NOT be written; no strobe after release.
REQ-032 After reset release, loader SHALL stay in IDLE until i_start.

Verification
REQ-033 i_start; stream 01, 80 00 00 00 05, checksum 85 -> one write addr 0 data 40'h8000000005, then o_cpu_run=1, o_error=0.
REQ-034 Same stream with checksum 00 -> o_error=1, o_cpu_run=0, exactly one write still occurred; next i_start clears o_error.
REQ-035 N=03, 15 bytes back-to-back with valid held high -> writes at addr 0,1,2 on cycles after bytes 5,10,15; no bytes dropped.
REQ-036 N=00 with 1280 bytes + correct checksum -> 256 writes, addr 0..255, then DONE.
REQ-037 Reset asserted after 3rd byte of a word -> o_mem_we never pulses; all outputs 0; valid bytes ignored until i_start.
REQ-038 i_start pulsed during DATA and byte_valid toggled randomly -> load completes unaffected, data matches expected words.

Source files
------------

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - byte-stream program loader that fills program memory and releases the CPU
//
// Purpose:
//    Accepts a load stream made of three parts:
//    - a header byte N giving the word count, where 0 means 2^ADDR_W words;
//    - N words of 5 bytes each, sent MSB first;
//    - an XOR checksum over all data bytes.
//    Each assembled word is written to program memory.
//    A matching checksum releases the CPU.
//    A mismatching checksum raises a sticky error and keeps the CPU held.
//
// Ports:
//    i_clk         - clock, rising edge
//    i_rst_n       - asynchronous active-low reset
//    i_start       - single-cycle load request (honoured in IDLE/DONE/ERR only)
//    i_byte        - load-stream byte
//    i_byte_valid  - i_byte valid this cycle
//    o_byte_ready  - loader accepts a byte this cycle (HDR/DATA/CSUM)
//    o_mem_we      - one-cycle program-memory write strobe
//    o_mem_addr    - write address (holds last written value)
//    o_mem_wdata   - write data (holds last written value)
//    o_cpu_run     - CPU may execute (DONE)
//    o_busy        - load in progress (HDR/DATA/CSUM)
//    o_error       - checksum failure (ERR), sticky until i_start or reset

module prog_loader #(
   parameter int ADDR_W = 8,
   parameter int WORD_W = 40
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_start,
   input  logic [7:0]        i_byte,
   input  logic              i_byte_valid,
   output logic              o_byte_ready,
   output logic              o_mem_we,
   output logic [ADDR_W-1:0] o_mem_addr,
   output logic [WORD_W-1:0] o_mem_wdata,
   output logic              o_cpu_run,
   output logic              o_busy,
   output logic              o_error
);

   // One extra bit so a full-depth count (2^ADDR_W) is representable.
   localparam int CNT_W = ADDR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      HDR  = 3'd1,
      DATA = 3'd2,
      CSUM = 3'd3,
      DONE = 3'd4,
      ERR  = 3'd5
   } state_t;

   state_t            state;
   logic [CNT_W-1:0]  word_cnt;
   logic [CNT_W-1:0]  word_idx;
   logic [2:0]        byte_cnt;
   logic [7:0]        csum;
   // First four bytes of the word being assembled; the fifth byte is
   // appended directly when the write is issued.
   logic [WORD_W-9:0] asm_q;
   logic              accept;

   // All status outputs are decoded from the state register only, so
   // they change on clock edges and never depend on inputs.
   assign o_byte_ready = (state == HDR) || (state == DATA) || (state == CSUM);
   assign o_busy       = o_byte_ready;
   assign o_cpu_run    = (state == DONE);
   assign o_error      = (state == ERR);
   assign accept       = i_byte_valid && o_byte_ready;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state       <= IDLE;
         word_cnt    <= '0;
         word_idx    <= '0;
         byte_cnt    <= '0;
         csum        <= '0;
         asm_q       <= '0;
         o_mem_we    <= 1'b0;
         o_mem_addr  <= '0;
         o_mem_wdata <= '0;
      end else begin
         o_mem_we <= 1'b0;
         case (state)
            IDLE, DONE, ERR: begin
               if (i_start) begin
                  state    <= HDR;
                  word_cnt <= '0;
                  word_idx <= '0;
                  byte_cnt <= '0;
                  csum     <= '0;
               end
            end
            HDR: begin
               if (accept) begin
                  word_cnt <= (i_byte == 8'd0) ? FULL_CNT : CNT_W'(i_byte);
                  state    <= DATA;
               end
            end
            DATA: begin
               if (accept) begin
                  csum <= csum ^ i_byte;
                  if (byte_cnt == 3'd4) begin
                     // Write is registered here; a byte accepted on the
                     // strobe cycle simply starts the next word.
                     o_mem_we    <= 1'b1;
                     o_mem_addr  <= word_idx[ADDR_W-1:0];
                     o_mem_wdata <= {asm_q, i_byte};
                     byte_cnt    <= 3'd0;
                     word_idx    <= word_idx + ONE_CNT;
                     if (word_idx + ONE_CNT == word_cnt) begin
                        state <= CSUM;
                     end
                  end else begin
                     asm_q    <= {asm_q[WORD_W-17:0], i_byte};
                     byte_cnt <= byte_cnt + 3'd1;
                  end
               end
            end
            CSUM: begin
               if (accept) begin
                  state <= (i_byte == csum) ? DONE : ERR;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
